// File: rtl/rf_param.sv
// rf_param: parametrised register file with byte-enabled writes,
// optional zero register, write-to-read bypass and a clear sweep.
module rf_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   RsAddr,
    input  logic [ADDR_W-1:0]   RtAddr,
    output logic [DATA_W-1:0]   RsData,
    output logic [DATA_W-1:0]   RtData,
    input  logic                RegWrite,
    input  logic [ADDR_W-1:0]   RdAddr,
    input  logic [DATA_W-1:0]   RdData,
    input  logic [DATA_W/8-1:0] ByteEn,
    input  logic                ClearReq,
    output logic                Busy,
    output logic                ClearDone
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {
        IDLE,
        SWEEP
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    logic [DATA_W-1:0] be_mask;
    logic [DATA_W-1:0] wr_merged;
    logic              wr_zero;
    logic              wr_acc;
    logic              rs_hit;
    logic              rt_hit;

    always_comb begin
        be_mask = '0;
        for (int i = 0; i < NB; i++) begin
            be_mask[8*i +: 8] = {8{ByteEn[i]}};
        end
    end

    assign wr_zero   = ZERO_REG && (RdAddr == '0);
    assign wr_acc    = RegWrite && !busy_q && !wr_zero;
    assign wr_merged = (regs_q[RdAddr] & ~be_mask) | (RdData & be_mask);
    assign rs_hit    = BYPASS && wr_acc && (RsAddr == RdAddr);
    assign rt_hit    = BYPASS && wr_acc && (RtAddr == RdAddr);

    // Zero-register masking wins over the bypass path.
    always_comb begin
        RsData = rs_hit ? wr_merged : regs_q[RsAddr];
        if (ZERO_REG && (RsAddr == '0)) begin
            RsData = '0;
        end
    end

    always_comb begin
        RtData = rt_hit ? wr_merged : regs_q[RtAddr];
        if (ZERO_REG && (RtAddr == '0)) begin
            RtData = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ClearReq) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            SWEEP: begin
                idx_d = idx_q + ADDR_W'(1);
                if (idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (state_q == SWEEP) begin
            regs_d[idx_q] = '0;
        end else if (wr_acc) begin
            regs_d[RdAddr] = wr_merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Busy      = busy_q;
    assign ClearDone = done_q;

endmodule

// File: tb/tb_rf_param.sv
// tb_rf_param: table vectors, directed sweep/reset sequences and
// random traffic against a behavioural register-file model.
module tb_rf_param;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  RsAddr, RtAddr, RdAddr;
    logic        RegWrite, ClearReq;
    logic [31:0] RdData;
    logic [3:0]  ByteEn;
    logic [31:0] rs_a, rt_a, rs_b, rt_b;
    logic        busy_a, done_a, busy_b, done_b;

    int total = 0;
    int bad = 0;

    logic [31:0] mem [DEPTH];
    int          m_left;
    bit          m_done;

    rf_param u_dut (
        .clk(clk), .rst_n(rst_n),
        .RsAddr(RsAddr), .RtAddr(RtAddr),
        .RsData(rs_a), .RtData(rt_a),
        .RegWrite(RegWrite), .RdAddr(RdAddr),
        .RdData(RdData), .ByteEn(ByteEn),
        .ClearReq(ClearReq),
        .Busy(busy_a), .ClearDone(done_a)
    );

    rf_param #(.BYPASS(1'b0)) u_nb (
        .clk(clk), .rst_n(rst_n),
        .RsAddr(RsAddr), .RtAddr(RtAddr),
        .RsData(rs_b), .RtData(rt_b),
        .RegWrite(RegWrite), .RdAddr(RdAddr),
        .RdData(RdData), .ByteEn(ByteEn),
        .ClearReq(ClearReq),
        .Busy(busy_b), .ClearDone(done_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] ers;
        logic [31:0] ert;
    } vec_t;

    vec_t tbl [8];

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(logic [31:0] old,
                                          logic [31:0] nw,
                                          logic [3:0] be);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        end
        return r;
    endfunction

    function automatic bit accepted();
        return RegWrite && (m_left == 0) && (RdAddr != 5'd0);
    endfunction

    function automatic logic [31:0] exp_rd(logic [4:0] a, bit byp);
        if (a == 5'd0) return 32'h0;
        if (byp && accepted() && (a == RdAddr))
            return merge(mem[a], RdData, ByteEn);
        return mem[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
        m_left = 0;
        m_done = 1'b0;
    endtask

    task automatic model_edge();
        bit          acc = accepted();
        logic [4:0]  wa = RdAddr;
        logic [31:0] wv = merge(mem[RdAddr], RdData, ByteEn);
        m_done = 1'b0;
        if (m_left > 0) begin
            mem[DEPTH - m_left] = 32'h0;
            m_left--;
            if (m_left == 0) m_done = 1'b1;
        end else if (ClearReq) begin
            m_left = DEPTH;
        end
        if (acc) mem[wa] = wv;
    endtask

    task automatic model_check();
        logic [31:0] eb = {31'b0, m_left > 0};
        logic [31:0] ed = {31'b0, m_done};
        check("rs_byp", rs_a, exp_rd(RsAddr, 1'b1));
        check("rt_byp", rt_a, exp_rd(RtAddr, 1'b1));
        check("rs_nobyp", rs_b, exp_rd(RsAddr, 1'b0));
        check("rt_nobyp", rt_b, exp_rd(RtAddr, 1'b0));
        check("busy", {31'b0, busy_a}, eb);
        check("done", {31'b0, done_a}, ed);
        check("busy_nb", {31'b0, busy_b}, eb);
        check("done_nb", {31'b0, done_b}, ed);
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        RegWrite = 1'b0;
        ClearReq = 1'b0;
        ByteEn = 4'hF;
    endtask

    task automatic wr(logic [4:0] a, logic [31:0] d);
        RegWrite = 1'b1;
        RdAddr = a;
        RdData = d;
        ByteEn = 4'hF;
        step();
        RegWrite = 1'b0;
    endtask

    initial begin
        int nbusy;
        int ndone;
        logic [31:0] old31;

        idle();
        RsAddr = 5'd0;
        RtAddr = 5'd0;
        RdAddr = 5'd0;
        RdData = 32'h0;
        model_reset();
        #12;
        check("rst_rs", rs_a, 32'h0);
        check("rst_busy", {31'b0, busy_a}, 32'h0);
        check("rst_done", {31'b0, done_a}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        tbl[0] = '{1'b1, 5'd3, 32'hAABBCCDD, 4'hF, 5'd3, 5'd0, 32'hAABBCCDD, 32'h0};
        tbl[1] = '{1'b1, 5'd3, 32'h11223344, 4'h5, 5'd3, 5'd3, 32'hAA22CC44, 32'hAA22CC44};
        tbl[2] = '{1'b0, 5'd0, 32'h0, 4'h0, 5'd3, 5'd3, 32'hAA22CC44, 32'hAA22CC44};
        tbl[3] = '{1'b1, 5'd0, 32'h12345678, 4'hF, 5'd0, 5'd0, 32'h0, 32'h0};
        tbl[4] = '{1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0, 32'h0, 32'h0};
        tbl[5] = '{1'b1, 5'd3, 32'hFFFFFFFF, 4'h0, 5'd3, 5'd3, 32'hAA22CC44, 32'hAA22CC44};
        tbl[6] = '{1'b1, 5'd7, 32'h00000055, 4'hF, 5'd7, 5'd7, 32'h55, 32'h55};
        tbl[7] = '{1'b0, 5'd0, 32'h0, 4'h0, 5'd7, 5'd3, 32'h55, 32'hAA22CC44};

        for (int i = 0; i < 8; i++) begin
            RegWrite = tbl[i].we;
            RdAddr = tbl[i].rd;
            RdData = tbl[i].wd;
            ByteEn = tbl[i].be;
            RsAddr = tbl[i].rs;
            RtAddr = tbl[i].rt;
            #1;
            check("tbl_rs", rs_a, tbl[i].ers);
            check("tbl_rt", rt_a, tbl[i].ert);
            if (i == 6) check("tbl_nobyp_old", rs_b, 32'h0);
            if (i == 7) check("tbl_nobyp_new", rs_b, 32'h55);
            step();
        end
        idle();

        RsAddr = 5'd5;
        RtAddr = 5'd5;
        wr(5'd5, 32'hDEADBEEF);
        #2;
        check("pre_rst", rs_a, 32'hDEADBEEF);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_rs", rs_a, 32'h0);
        check("async_rst_rt_nb", rt_b, 32'h0);
        check("async_rst_busy", {31'b0, busy_a}, 32'h0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int a = 1; a < DEPTH; a++) begin
            RsAddr = 5'(a);
            RtAddr = 5'(a - 1);
            wr(5'(a), $urandom | 32'h1);
        end
        old31 = mem[31];
        ClearReq = 1'b1;
        step();
        ClearReq = 1'b0;
        nbusy = 0;
        ndone = 0;
        for (int c = 0; c < 36; c++) begin
            RegWrite = (c == 5);
            RdAddr = 5'd2;
            RdData = 32'hFFFFFFFF;
            ByteEn = 4'hF;
            RsAddr = (c == 10) ? 5'd31 : 5'($urandom);
            RtAddr = 5'd2;
            #1;
            if (busy_a) nbusy++;
            if (done_a) ndone++;
            if (c == 10) check("r31_mid_sweep", rs_a, old31);
            if (c == 32) check("done_after_busy", {31'b0, done_a}, 32'h1);
            step();
        end
        idle();
        check("busy_len", 32'(nbusy), 32'd32);
        check("done_cnt", 32'(ndone), 32'd1);
        for (int a = 0; a < DEPTH; a++) begin
            RsAddr = 5'(a);
            RtAddr = 5'(a);
            #1;
            check("cleared", rs_a, 32'h0);
            step();
        end

        for (int a = 20; a < 26; a++) wr(5'(a), 32'hC0DE0000 | 32'(a));
        ClearReq = 1'b1;
        step();
        ClearReq = 1'b0;
        for (int c = 0; c < 12; c++) step();
        #2;
        check("mid_busy", {31'b0, busy_a}, 32'h1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_busy", {31'b0, busy_a}, 32'h0);
        check("mid_rst_done", {31'b0, done_a}, 32'h0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ndone = 0;
        for (int a = 0; a < 40; a++) begin
            RsAddr = 5'(a);
            RtAddr = 5'(a + 7);
            #1;
            if (done_a) ndone++;
            step();
        end
        check("no_done_after_rst", 32'(ndone), 32'd0);

        ClearReq = 1'b1;
        for (int c = 0; c < 70; c++) begin
            RsAddr = 5'($urandom);
            RtAddr = 5'($urandom);
            step();
        end
        idle();
        for (int c = 0; c < 40; c++) step();

        for (int c = 0; c < 500; c++) begin
            RegWrite = 1'($urandom);
            RdAddr = 5'($urandom);
            RdData = $urandom;
            ByteEn = 4'($urandom);
            RsAddr = ($urandom_range(0, 3) == 0) ? RdAddr : 5'($urandom);
            RtAddr = ($urandom_range(0, 3) == 0) ? RdAddr : 5'($urandom);
            ClearReq = ($urandom_range(0, 59) == 0);
            step();
        end
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_param.md
# rf_param

Parametrised general-purpose register file for the single-cycle and upcoming pipelined CPU datapaths. It replaces the fixed 32×32 register file with configurable data width and register count, and adds:
- asynchronous clear on reset;
- an optional hard-wired zero register;
- byte-enabled writes;
- a write-to-read bypass;
- a handshaked sequential clear sweep that zeroes the whole file without a reset.

It sits between instruction decode (read addresses) and write-back (write address and data).

## Interface
Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 1, when 1, register 0 always reads 0 and writes to it are discarded.
- BYPASS, 1, when 1, an accepted same-cycle write is forwarded to matching read ports.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- RsAddr  in  ADDR_W  read port A address.
- RtAddr  in  ADDR_W  read port B address.
- RsData  out  DATA_W  read port A data (combinational).
- RtData  out  DATA_W  read port B data (combinational).
- RegWrite  in  1  write request.
- RdAddr  in  ADDR_W  write address.
- RdData  in  DATA_W  write data.
- ByteEn  in  DATA_W/8  per-byte write enable; bit i covers RdData[8i+7:8i].
- ClearReq  in  1  request a full-file clear sweep.
- Busy  out  1  high while a sweep is in progress; CPU must stall write-back.
- ClearDone  out  1  one-cycle pulse after the last register is cleared.

## Operation
- **Reset.** While rst_n is low, all DEPTH registers are 0, the FSM is in IDLE, sweep index is 0, Busy=0 and ClearDone=0. Reset takes effect immediately, independent of clk.
- **Write acceptance.** A write is accepted when RegWrite=1, Busy=0, and not (ZERO_REG=1 and RdAddr=0).
- **Write effect.** An accepted write updates, at the rising edge, only the bytes whose ByteEn bit is 1. If ByteEn is all 0, there is no change.
- **Reads.** Reads are combinational from the stored array.
  - With ZERO_REG=1, address 0 returns 0 regardless of contents.
  - With BYPASS=1, a read port whose address equals RdAddr during an accepted write returns the merge of stored data and RdData under ByteEn. This gives same-cycle read-after-write visibility; no bypass is applied while Busy=1.
  - With BYPASS=0, reads show the new value from the cycle after the write edge.
- **FSM states:** IDLE, SWEEP.
  - **IDLE:**
    - ClearReq=1 at an edge: go to SWEEP, index=0, Busy=1.
    - Otherwise: remain in IDLE.
    - A write accepted at that same edge still commits.
  - **SWEEP:**
    - Each edge writes R[index]=0 and increments index.
    - The edge that clears index DEPTH-1: go to IDLE, Busy=0, ClearDone=1 for exactly one cycle, index wraps to 0.
    - ClearReq while in SWEEP is ignored; it is not queued.
    - RegWrite while Busy=1 is dropped, not buffered.
    - Reads during SWEEP return current stored contents: registers below index read 0, and registers at or above index read their old value.
- **Reset mid-sweep:** everything is cleared immediately, the FSM returns to IDLE, and no ClearDone is generated.
- **ClearReq on the ClearDone cycle:** the FSM is in IDLE on that cycle, so the request starts a new sweep.
- **Index width:** the index is ADDR_W bits; it wraps naturally at DEPTH.

## Timing
- **Read latency:** 0 cycles (combinational from address).
- **Write latency:**
  - Visible on read ports in the same cycle with BYPASS=1.
  - Visible in the next cycle with BYPASS=0.
- **Sweep duration:** Busy is high for exactly DEPTH cycles, starting the cycle after ClearReq is sampled. ClearDone is asserted the cycle after Busy falls, for one cycle.
- **Outputs after reset release:** Busy=0, ClearDone=0, RsData=RtData=0.
- **Handshake:** ClearReq is level-sampled only in IDLE, so holding it high produces back-to-back sweeps.

## Test plan
- **Reset:** write 0xDEADBEEF to R5, pulse rst_n low mid-cycle → RsAddr=5 reads 0 immediately, before the next clock edge; Busy=0.
- **Zero register:** ZERO_REG=1, write 0x12345678 to R0 → RsData at address 0 reads 0; the next cycle also reads 0.
- **Byte enables:** write 0xAABBCCDD to R3 with ByteEn=1111, then 0x11223344 with ByteEn=0101 → R3 reads 0xAA22CC44.
- **Bypass:** BYPASS=1, RsAddr=RtAddr=RdAddr=7, RegWrite=1, RdData=0x55 → both ports read 0x55 in the same cycle. With BYPASS=0, they read the old value, then 0x55 the next cycle.
- **Clear sweep:** fill all registers with nonzero values, pulse ClearReq → Busy is high for 32 cycles. Reading R31 at sweep cycle 10 returns its old value. A RegWrite to R2 at sweep cycle 5 is dropped. ClearDone pulses once, and all registers then read 0.
- **Reset mid-sweep:** assert rst_n low at sweep cycle 12 → Busy=0 immediately, no ClearDone, and all registers read 0.
